digit_scan_mux: RTL and testbench
=================================

DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed display digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 1000: clock cycles each digit is driven, legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  request to capture data_in; accepted only in a cycle where ready=1.
REQ-006 data_in  input  3*NUM_DIGITS  packed digit codes; digit k is bits [3k+2:3k].
REQ-007 ready  output  1  high when no update is pending; load is accepted only while high.
REQ-008 A, B, C  output  1 each  3-bit code of the active digit, A=MSB, driven straight into the 7-segment decoder inputs.
REQ-009 dig_en  output  NUM_DIGITS  active-high digit enable, one-hot or all-zero.

Function
REQ-010 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-011 A 16-bit prescaler SHALL count 0..SCAN_DIV-1 and wrap; the terminal count (SCAN_DIV-1) is the digit-advance event.
REQ-012 The digit index SHALL advance 0,1,..,NUM_DIGITS-1,0 on each digit-advance event; the wrap NUM_DIGITS-1->0 is the frame boundary.
REQ-013 While digit k is active: dig_en = one-hot bit k; {A,B,C} = display register bits [3k+2:3k].
REQ-014 Each digit SHALL be driven for exactly SCAN_DIV consecutive cycles (plus the blank cycle of REQ-024 when enabled).
REQ-015 load=1 with ready=1: data_in captured into the pending register on that edge; ready=0 from the next cycle.
REQ-016 load=1 with ready=0: ignored; pending register unchanged.
REQ-017 At the frame boundary with an update pending: pending copied into the display register on the same edge at which the index returns to 0, so digit 0 of the new frame shows new data; ready=1 from the next cycle.
REQ-018 An update SHALL never take effect mid-frame; all digits of one frame come from a single display-register value.
REQ-019 A load accepted in the same cycle as a frame boundary SHALL be applied at the following frame boundary, not the current one.
REQ-020 Operating states: SCAN (digit driven); BLANK exists only per REQ-024.

Reset
REQ-021 While rst=1: dig_en=0, A=B=C=0, ready=1, prescaler=0, index=0, display and pending registers=0, state=SCAN.
REQ-022 On the first rising edge after rst falls: dig_en=bit 0, {A,B,C}=000; the prescaler starts at 0.
REQ-023 rst asserted mid-frame or with an update pending SHALL discard the pending update and force REQ-021 values immediately, without waiting for a clock.

Configuration
REQ-024 Macro SCAN_BLANK_EN defined: every digit-advance event enters BLANK for exactly one cycle (dig_en=0, A=B=C=0, prescaler held at 0), then SCAN of the next digit; a frame boundary update still lands on the edge entering digit 0.
REQ-025 Macro SCAN_BLANK_EN undefined: BLANK state and its logic are absent; the next digit is driven on the cycle immediately after the terminal count.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-026 rst pulse, then free-run -> dig_en cycles 0001,0010,0100,1000,0001, 4 cycles each; A,B,C=000 throughout; ready=1.
REQ-027 With ready=1, load pulse with data_in=12'o7531 mid-frame -> ready=0 next cycle; remainder of the current frame unchanged; next frame shows digits 1,3,5,7 on dig_en 0001..1000; ready=1 one cycle after the boundary.
REQ-028 Second load with data_in=12'o2222 while ready=0 -> ignored; display shows 7531 values; no further ready drop.
REQ-029 load asserted exactly on the frame-boundary cycle -> new data appears one full frame later, not in the frame just started.
REQ-030 rst asserted while an update is pending -> outputs zero asynchronously; after release, A,B,C=000 on all digits and ready=1.
REQ-031 SCAN_BLANK_EN defined -> one all-zero dig_en cycle between digits; frame period 20 cycles; undefined -> frame period 16 cycles, dig_en never all-zero after reset.

Source files
------------

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed driver for a bank of 7-segment digits.
// Optional one-cycle blanking between digits when SCAN_BLANK_EN is defined.
module digit_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [3*NUM_DIGITS-1:0] data_in,
    output logic                    ready,
    output logic                    A,
    output logic                    B,
    output logic                    C,
    output logic [NUM_DIGITS-1:0]   dig_en
);

    localparam int DW = 3 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [15:0]   TERM = 16'(SCAN_DIV - 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

`ifdef SCAN_BLANK_EN
    typedef enum logic [0:0] {
        SCAN  = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t state_q, state_d;
`endif

    logic [15:0]           presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  ready_d;
    logic [NUM_DIGITS-1:0] dig_en_d;
    logic [2:0]            abc_d;
    logic                  adv;

    // Next-state: prescaler, digit index, frame-boundary update, load capture
    always_comb begin
        presc_d  = presc_q;
        idx_d    = idx_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        ready_d  = ready;
        dig_en_d = '0;
        abc_d    = 3'b000;
        adv      = 1'b0;
`ifdef SCAN_BLANK_EN
        state_d  = state_q;
        unique case (state_q)
            SCAN: begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (idx_q == IW'(k)) begin
                        dig_en_d[k] = 1'b1;
                        abc_d       = disp_q[3*k +: 3];
                    end
                end
                if (presc_q == TERM) begin
                    presc_d = 16'd0;
                    state_d = BLANK;
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
            BLANK: begin
                adv     = 1'b1;
                state_d = SCAN;
            end
        endcase
`else
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                dig_en_d[k] = 1'b1;
                abc_d       = disp_q[3*k +: 3];
            end
        end
        if (presc_q == TERM) begin
            presc_d = 16'd0;
            adv     = 1'b1;
        end else begin
            presc_d = presc_q + 16'd1;
        end
`endif
        // Pending data only lands when the index wraps to digit 0
        if (adv) begin
            if (idx_q == LAST) begin
                idx_d = '0;
                if (!ready) begin
                    disp_d  = pend_q;
                    ready_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        // A load uses the pre-edge ready, so a boundary load waits a frame
        if (load && ready) begin
            pend_d  = data_in;
            ready_d = 1'b0;
        end
    end

    // State and registered outputs, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= 16'd0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            ready   <= 1'b1;
            dig_en  <= '0;
            A       <= 1'b0;
            B       <= 1'b0;
            C       <= 1'b0;
`ifdef SCAN_BLANK_EN
            state_q <= SCAN;
`endif
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            ready   <= ready_d;
            dig_en  <= dig_en_d;
            A       <= abc_d[2];
            B       <= abc_d[1];
            C       <= abc_d[0];
`ifdef SCAN_BLANK_EN
            state_q <= state_d;
`endif
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux: directed + random stimulus against a positional model.
// Frame timing is derived from edge count; data from a frame-level model.
module tb_digit_scan_mux;

    localparam int ND  = 4;
    localparam int DIV = 4;
`ifdef SCAN_BLANK_EN
    localparam int SL = DIV + 1;
`else
    localparam int SL = DIV;
`endif
    localparam int P = ND * SL;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [11:0] data_in;
    logic        ready;
    logic        A, B, C;
    logic [3:0]  dig_en;

    int checks = 0;
    int errors = 0;
    int n;
    logic [11:0] m_disp, m_pend;
    logic        m_ready;

    digit_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in),
        .ready(ready), .A(A), .B(B), .C(C), .dig_en(dig_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h",
                   tag, n, obs, exp);
        end
    endtask

    // Checks outputs with no clock edge in between: reset is asynchronous
    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, 32'(dig_en), 32'd0);
        chk({tag, "_abc"}, 32'({A, B, C}), 32'd0);
        chk({tag, "_rdy"}, 32'(ready), 32'd1);
    endtask

    task automatic do_reset();
        load    = 1'b0;
        data_in = '0;
        rst     = 1'b1;
        #1;
        chk_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_hold");
        @(negedge clk);
        rst     = 1'b0;
        n       = 0;
        m_disp  = '0;
        m_pend  = '0;
        m_ready = 1'b1;
    endtask

    // One clock: expected outputs come from the slot position within the
    // frame and the display value the frame was started with
    task automatic step(input logic ld, input logic [11:0] d);
        int p, slot, off;
        logic [3:0] e_en;
        logic [2:0] e_abc;
        logic       was_ready;
        load    = ld;
        data_in = d;
        @(posedge clk);
        n++;
        p    = (n - 1) % P;
        slot = p / SL;
        off  = p % SL;
        if (off >= DIV) begin
            e_en  = 4'd0;
            e_abc = 3'd0;
        end else begin
            e_en  = 4'(1 << slot);
            e_abc = 3'((m_disp >> (3 * slot)) & 12'd7);
        end
        was_ready = m_ready;
        if ((n % P) == 0 && !was_ready) begin
            m_disp  = m_pend;
            m_ready = 1'b1;
        end
        if (ld && was_ready) begin
            m_pend  = d;
            m_ready = 1'b0;
        end
        #1;
        chk("dig_en", 32'(dig_en), 32'(e_en));
        chk("abc", 32'({A, B, C}), 32'(e_abc));
        chk("ready", 32'(ready), 32'(m_ready));
        load = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        data_in = '0;
        #2;
        do_reset();

        // Free run: zero data, one-hot scan
        for (int i = 0; i < 2 * P; i++) step(1'b0, 12'd0);

        // Mid-frame load of 7531
        while ((n % P) != 6) step(1'b0, 12'd0);
        step(1'b1, 12'o7531);
        chk("ready_drop", 32'(ready), 32'd0);
        step(1'b0, 12'd0);
        // Ignored while pending
        step(1'b1, 12'o2222);
        for (int i = 0; i < 2 * P; i++) step(1'b0, 12'd0);
        chk("disp_7531", 32'(m_disp), 32'(12'o7531));

        // Load on the frame-boundary edge waits a full frame
        while (((n + 1) % P) != 0) step(1'b0, 12'd0);
        step(1'b1, 12'o4646);
        for (int i = 0; i < 2 * P + 3; i++) step(1'b0, 12'd0);

        // Reset with an update pending
        step(1'b1, 12'o3333);
        step(1'b0, 12'd0);
        #2;
        do_reset();
        for (int i = 0; i < P + 2; i++) step(1'b0, 12'd0);

        // Random loads
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) == 0), 12'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
